// File: rtl/ddhw_bcd_pkg.sv
// Shared BCD constants, the digit type and the nibble validity check
// used by the multi-decade counter.
package ddhw_bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_digit_t nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_counter_ndigit_if.sv
// Control and data bundle of the BCD counter. The master side drives requests.
// The slave side is the counter itself.
interface bcd_counter_ndigit_if #(
    parameter int DIGITS = 2
) ();

    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output en, up, load, load_value,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up, load, load_value,
        output count, tc, wrap, load_err
    );

endinterface

// File: rtl/bcd_decade.sv
// One BCD decade. It loads a digit, or it steps up or down by one with a 9<->0 roll.
// at_limit marks the digit that would roll over in the current direction.
module bcd_decade
    import ddhw_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       step_in,
    input  logic       load,
    input  bcd_digit_t ld_digit,
    output bcd_digit_t digit,
    output logic       at_limit
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        // NOTE: default first so every path assigns digit_d and no latch is inferred.
        digit_d = digit_q;
        if (load) begin
            digit_d = ld_digit;
        end else if (step_in) begin
            if (up) digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            else    digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking updates keep every flop sampling pre-edge values.
        if (reset) digit_q <= BCD_MIN;
        else       digit_q <= digit_d;
    end

    assign digit    = digit_q;
    assign at_limit = up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// Multi-decade BCD up/down counter. It has a validated parallel load and a
// wrap or saturate boundary. It also drives the tc, wrap and load_err flags.
module bcd_counter_ndigit
    import ddhw_bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_counter_ndigit_if.slave  bus
);

    logic [DIGITS-1:0]   at_limit;
    logic [DIGITS-1:0]   step_in;
    logic [DIGITS:0]     chain;
    logic [4*DIGITS-1:0] count_w;
    logic                load_ok;
    logic                load_apply;
    logic                all_limit;
    logic                count_en;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            load_ok = load_ok & is_bcd(bus.load_value[4*i +: 4]);
        end
    end

    // chain[i] is high when every decade below i sits at its limit
    always_comb begin
        chain[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            chain[i+1] = chain[i] & at_limit[i];
        end
    end

    assign all_limit  = chain[DIGITS];
    assign load_apply = bus.load & load_ok;
    assign count_en   = bus.en & ~bus.load & ~(all_limit & ~WRAP_EN);
    assign step_in    = {DIGITS{count_en}} & chain[DIGITS-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_decade
        bcd_decade u_decade (
            .clk      (clk),
            .reset    (reset),
            .up       (bus.up),
            .step_in  (step_in[g]),
            .load     (load_apply),
            .ld_digit (bus.load_value[4*g +: 4]),
            .digit    (count_w[4*g +: 4]),
            .at_limit (at_limit[g])
        );
    end

    assign wrap_d     = count_en & all_limit;
    assign load_err_d = bus.load & ~load_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_w;
    assign bus.tc       = all_limit;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench for the BCD counter. It uses three instances: 2-digit wrap,
// 2-digit saturate and 3-digit wrap.
module tb_bcd_counter_ndigit;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bcd_counter_ndigit_if #(.DIGITS(2)) ifa ();
    bcd_counter_ndigit_if #(.DIGITS(2)) ifb ();
    bcd_counter_ndigit_if #(.DIGITS(3)) ifc ();

    bcd_counter_ndigit #(.DIGITS(2), .WRAP_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    bcd_counter_ndigit #(.DIGITS(2), .WRAP_EN(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    bcd_counter_ndigit #(.DIGITS(3), .WRAP_EN(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bcd(input string tag, input logic [31:0] v, input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < digits; i++) begin
            if (!(v[4*i +: 4] <= 4'd9)) ok = 1'b0;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] t2_exp [7];
        logic       t2_wrap [7];
        int         e;

        ifa.en = 1'b0; ifa.up = 1'b1; ifa.load = 1'b0; ifa.load_value = '0;
        ifb.en = 1'b0; ifb.up = 1'b0; ifb.load = 1'b0; ifb.load_value = '0;
        ifc.en = 1'b0; ifc.up = 1'b1; ifc.load = 1'b0; ifc.load_value = '0;

        // Asynchronous reset mid-cycle at t=2
        #2 reset = 1'b1;
        #1;
        check("rst a count", 32'(ifa.count), 32'h00);
        check("rst a wrap", 32'(ifa.wrap), 32'd0);
        check("rst a load_err", 32'(ifa.load_err), 32'd0);
        check("rst a tc up", 32'(ifa.tc), 32'd0);
        check("rst b tc down", 32'(ifb.tc), 32'd1);
        check("rst c count", 32'(ifc.count), 32'h000);
        #5 reset = 1'b0;

        // Test 1: count up through 100 edges with one wrap
        ifa.en = 1'b1; ifa.up = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            e = k % 100;
            check($sformatf("t1 count k=%0d", k), 32'(ifa.count), 32'(((e / 10) << 4) | (e % 10)));
            check($sformatf("t1 wrap k=%0d", k), 32'(ifa.wrap), 32'(k == 100));
            check($sformatf("t1 tc k=%0d", k), 32'(ifa.tc), 32'(e == 99));
            check_bcd($sformatf("t1 bcd k=%0d", k), 32'(ifa.count), 2);
        end
        ifa.en = 1'b0;

        // Test 2: load 0x05 then count down across the wrap
        ifa.load = 1'b1; ifa.load_value = 8'h05;
        tick();
        check("t2 load", 32'(ifa.count), 32'h05);
        check("t2 load wrap", 32'(ifa.wrap), 32'd0);
        t2_exp  = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99, 8'h98};
        t2_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ifa.load = 1'b0; ifa.en = 1'b1; ifa.up = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("t2 count i=%0d", i), 32'(ifa.count), 32'(t2_exp[i]));
            check($sformatf("t2 wrap i=%0d", i), 32'(ifa.wrap), 32'(t2_wrap[i]));
            check_bcd($sformatf("t2 bcd i=%0d", i), 32'(ifa.count), 2);
            if (i == 4) begin
                check("t2 tc at 00 down", 32'(ifa.tc), 32'd1);
                ifa.up = 1'b1;
                #1 check("t2 tc at 00 up", 32'(ifa.tc), 32'd0);
                ifa.up = 1'b0;
                #1;
            end
        end
        ifa.en = 1'b0;

        // Test 3: reject non-BCD loads and keep the count
        ifa.load = 1'b1; ifa.load_value = 8'h42;
        tick();
        check("t3 load 42", 32'(ifa.count), 32'h42);
        ifa.load_value = 8'h3A;
        tick();
        check("t3 bad 3A count", 32'(ifa.count), 32'h42);
        check("t3 bad 3A err", 32'(ifa.load_err), 32'd1);
        check("t3 bad 3A wrap", 32'(ifa.wrap), 32'd0);
        ifa.load_value = 8'h57;
        tick();
        check("t3 load 57", 32'(ifa.count), 32'h57);
        check("t3 load 57 err", 32'(ifa.load_err), 32'd0);
        ifa.load_value = 8'hF0;
        tick();
        check("t3 bad F0 count", 32'(ifa.count), 32'h57);
        check("t3 bad F0 err", 32'(ifa.load_err), 32'd1);
        ifa.load = 1'b0;
        tick();
        check("t3 hold err", 32'(ifa.load_err), 32'd0);
        check("t3 hold count", 32'(ifa.count), 32'h57);

        // Test 4: saturating instance at both ends
        ifb.load = 1'b1; ifb.load_value = 8'h98;
        tick();
        check("t4 load 98", 32'(ifb.count), 32'h98);
        ifb.load = 1'b0; ifb.en = 1'b1; ifb.up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4 sat count i=%0d", i), 32'(ifb.count), 32'h99);
            check($sformatf("t4 sat wrap i=%0d", i), 32'(ifb.wrap), 32'd0);
            check($sformatf("t4 sat tc i=%0d", i), 32'(ifb.tc), 32'd1);
        end
        ifb.up = 1'b0;
        tick();
        check("t4 down 98", 32'(ifb.count), 32'h98);
        ifb.en = 1'b0; ifb.load = 1'b1; ifb.load_value = 8'h00;
        tick();
        check("t4 load 00", 32'(ifb.count), 32'h00);
        ifb.load = 1'b0; ifb.en = 1'b1;
        tick();
        check("t4 sat low count", 32'(ifb.count), 32'h00);
        check("t4 sat low wrap", 32'(ifb.wrap), 32'd0);
        check("t4 sat low tc", 32'(ifb.tc), 32'd1);
        check("t4 load_err", 32'(ifb.load_err), 32'd0);
        ifb.en = 1'b0;

        // Test 5: load wins over count enable; a single-edge carry across two digits follows
        ifc.load = 1'b1; ifc.en = 1'b1; ifc.up = 1'b1; ifc.load_value = 12'h199;
        tick();
        check("t5 load+en", 32'(ifc.count), 32'h199);
        check("t5 load+en wrap", 32'(ifc.wrap), 32'd0);
        ifc.load = 1'b0;
        tick();
        check("t5 carry", 32'(ifc.count), 32'h200);
        ifc.up = 1'b0;
        tick();
        check("t5 borrow", 32'(ifc.count), 32'h199);
        check("t5 tc", 32'(ifc.tc), 32'd0);
        check("t5 load_err", 32'(ifc.load_err), 32'd0);
        check_bcd("t5 bcd", 32'(ifc.count), 3);
        ifc.en = 1'b0;

        // Test 6: async reset between edges while counting at 0x37
        ifa.load = 1'b1; ifa.load_value = 8'h36;
        tick();
        ifa.load = 1'b0; ifa.en = 1'b1; ifa.up = 1'b1;
        tick();
        check("t6 count 37", 32'(ifa.count), 32'h37);
        #2 reset = 1'b1;
        #1;
        check("t6 async count", 32'(ifa.count), 32'h00);
        check("t6 async wrap", 32'(ifa.wrap), 32'd0);
        #1 reset = 1'b0;
        tick();
        check("t6 first edge", 32'(ifa.count), 32'h01);
        check("t6 first edge wrap", 32'(ifa.wrap), 32'd0);
        ifa.en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
